dff: RTL and testbench
======================

Name: dff

Overview:
- Edge-triggered D flip-flop: a single storage element that samples D on the rising clock edge.
- Asynchronous active-high reset clears the stored value.
- Leaf primitive for registering control/data bits in sequential logic.
- Parameterised width so the same block serves 1-bit flags and multi-bit buses.

Parameters:
- WIDTH, 1, bit width of D and Q.
- RST_VAL, {WIDTH{1'b0}}, value loaded into Q while rst is asserted.

Ports:
- clk  input  1  clock; all capture on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- D  input  WIDTH  data to capture.
- Q  output  WIDTH  registered data.
- Port order is fixed as clk, rst, D, Q so positional instantiation works.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset assertion: on the rising edge of rst, Q becomes RST_VAL immediately, with no wait for clk.
- Reset held: while rst=1, Q holds RST_VAL regardless of clk edges or D activity.
- Normal operation: on each posedge clk with rst=0, Q <= D. Latency is one clock edge.
- Between edges: Q holds its value; D changes between edges have no effect on Q.
- Reset release: deassertion has no immediate effect. The first posedge clk with rst=0 loads D.
- Simultaneous edges: if posedge clk and rst rise together, reset wins and Q=RST_VAL.
- Release coincident with an edge: if rst falls at the same instant as posedge clk, the block is not required to capture D on that edge. Q must be RST_VAL or D, never X, and integrators must meet recovery/removal timing.
- Power-up: Q is undefined (X in simulation) until the first reset or the first posedge clk. No initial value is required.
- Output registering: Q is driven directly from the storage element, with no combinational path from D to Q.
- Width: D and Q are the same width; there is no truncation or extension.
- Coding: a single always block sensitive to posedge clk and posedge rst, using non-blocking assignment.

Decomposition:
- No shared package is needed. RST_VAL is local to the block.
- No sub-modules. This is a leaf cell, and wider registers instantiate it with WIDTH > 1.

Test Plan:
- Basic capture: clk period 20 ns with rising edges at 0, 20, 40, 60…; rst=0; D 0→1 at t=5. Q=1 from the t=20 edge; Q does not change at t=5.
- Async reset: with Q=1, D=1, assert rst at t=55, between edges. Q=0 at t=55 without waiting for the t=60 edge.
- Reset dominance: rst=1 held; D toggles 1→0→1 across edges at 60, 80, 100. Q stays 0 throughout.
- Reset release: D=1, deassert rst mid-cycle. Q stays 0 until the next posedge, then Q=1.
- Hold/no-glitch: rst=0, Q=0; pulse D=1 for 5 ns strictly between edges. Q remains 0.
- Parameterised: WIDTH=8, RST_VAL=8'hA5; D=8'h3C captured gives Q=8'h3C; rst pulse gives Q=8'hA5 immediately.

Source files
------------

// File: rtl/dff.sv
// dff: parameterised edge-triggered D flip-flop with asynchronous active-high reset.
//   clk : clock, capture on rising edge
//   rst : asynchronous active-high reset, loads RST_VAL immediately
//   D   : data to capture (WIDTH bits)
//   Q   : registered data (WIDTH bits), driven straight from the storage element
module dff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Storage element; reset dominates any coincident clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= RST_VAL;
    end else begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_dff.sv
`timescale 1ns/1ps
// tb_dff: directed bench for dff, covering a 1-bit default instance and an
// 8-bit instance with a non-zero reset value.
module tb_dff;

  logic       clk;
  logic       rst;
  logic       d1;
  logic       q1;
  logic       rst8;
  logic [7:0] d8;
  logic [7:0] q8;

  int checks = 0;
  int errors = 0;

  dff u_dff1 (
    .clk (clk),
    .rst (rst),
    .D   (d1),
    .Q   (q1)
  );

  dff #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) u_dff8 (
    .clk (clk),
    .rst (rst8),
    .D   (d8),
    .Q   (q8)
  );

  // 20 ns clock, rising edges at 0, 20, 40, ...
  initial begin
    clk = 1'b0;
    forever begin
      clk = 1'b1;
      #10;
      clk = 1'b0;
      #10;
    end
  end

  task automatic at(input time t);
    if (t > $time) #(t - $time);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    d1   = 1'b0;
    rst8 = 1'b1;
    d8   = 8'h00;

    at(2);   check("reset_q1",       {7'd0, q1}, 8'h00);
             check("reset_q8",       q8,         8'hA5);
    at(3);   rst = 1'b0; rst8 = 1'b0;
    at(5);   d1 = 1'b1; d8 = 8'h3C;
    at(6);   check("no_capture_mid", {7'd0, q1}, 8'h00);
             check("no_capture_8",   q8,         8'hA5);
    at(21);  check("capture_1",      {7'd0, q1}, 8'h01);
             check("capture_3c",     q8,         8'h3C);

    // Asynchronous assertion between edges
    at(55);  rst = 1'b1;
    at(56);  check("async_rst",      {7'd0, q1}, 8'h00);

    // Reset held while D toggles across edges
    at(61);  check("hold_rst_60",    {7'd0, q1}, 8'h00);
    at(65);  d1 = 1'b0;
    at(81);  check("hold_rst_80",    {7'd0, q1}, 8'h00);
    at(85);  d1 = 1'b1;
    at(101); check("hold_rst_100",   {7'd0, q1}, 8'h00);
    at(105); d1 = 1'b0;
    at(121); check("hold_rst_120",   {7'd0, q1}, 8'h00);

    // Release mid-cycle: no effect until the next rising edge
    at(125); d1 = 1'b1;
    at(130); rst = 1'b0;
    at(131); check("release_wait",   {7'd0, q1}, 8'h00);
    at(141); check("release_load",   {7'd0, q1}, 8'h01);

    // Short D pulse strictly between edges must not reach Q
    at(145); d1 = 1'b0;
    at(161); check("load_zero",      {7'd0, q1}, 8'h00);
    at(165); d1 = 1'b1;
    at(170); d1 = 1'b0;
    at(175); check("glitch_mid",     {7'd0, q1}, 8'h00);
    at(181); check("glitch_edge",    {7'd0, q1}, 8'h00);
    at(185); d1 = 1'b1;
    at(201); check("recapture",      {7'd0, q1}, 8'h01);

    // 8-bit reset pulse loads A5 immediately
    at(210); rst8 = 1'b1;
    at(211); check("pulse_a5",       q8,         8'hA5);
    at(215); rst8 = 1'b0; d8 = 8'h5A;
    at(216); check("release_hold8",  q8,         8'hA5);
    at(221); check("capture_5a",     q8,         8'h5A);

    // Reset rising together with a clock edge: reset wins
    at(235); d8 = 8'hFF;
    at(240); rst8 = 1'b1;
    at(241); check("coincident_rst", q8,         8'hA5);
    at(261); check("coincident_hold", q8,        8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
